// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_pkg
// Shared constants for the memory-port arbiter: stall patterns, state codes.
// Revision: 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order of the stall vector: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = {{4{NO_STOP}}, {2{STOP}}};
    localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, {5{STOP}}};

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0]  SEL_WORD  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_BUSY  = 3'd1,
        ST_MEM_BUSY = 3'd2,
        ST_IF_DONE  = 3'd3,
        ST_MEM_DONE = 3'd4
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_if
// Requester, pipeline-control and external memory bus signals of the arbiter.
// Revision: 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              flush;
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic [5:0]        stall;
    logic              bus_err;

    // master: the arbiter, which masters the external bus
    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  stallreq_id, stallreq_ex, flush, bus_rdata, bus_ack,
        output if_rdata, mem_rdata, bus_req, bus_we, bus_sel, bus_addr,
        output bus_wdata, stall, bus_err
    );

    // slave: pipeline stages and the memory slave around the arbiter
    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output stallreq_id, stallreq_ex, flush, bus_rdata, bus_ack,
        input  if_rdata, mem_rdata, bus_req, bus_we, bus_sel, bus_addr,
        input  bus_wdata, stall, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_stall_encoder.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_stall_encoder
// Priority encoder from stall requests to the 6-bit pipeline stall vector.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter_stall_encoder
    import mem_bus_arbiter_pkg::*;
(
    input  wire logic       arb_mem,
    input  wire logic       stallreq_ex,
    input  wire logic       stallreq_id,
    input  wire logic       arb_if,
    output logic [5:0]      stall
);

    always_comb begin
        stall = STALL_NONE;
        if (arb_mem)
            stall = STALL_MEM;
        else if (stallreq_ex)
            stall = STALL_EX;
        else if (stallreq_id)
            stall = STALL_ID;
        else if (arb_if)
            stall = STALL_IF;
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter
// Shares the external memory port between IF and MEM and builds the stall
// vector. Optional bus watchdog enabled by MEM_BUS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_bus_arbiter_if.master  bus
);

    arb_state_e        r_state;
    logic              r_discard;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [3:0]        r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_idle;
    logic              w_arb_mem;
    logic              w_arb_if;
    logic [5:0]        w_stall;
    logic              w_timeout;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_bus_err;
    logic            w_busy;

    assign w_busy    = (r_state == ST_IF_BUSY) || (r_state == ST_MEM_BUSY);
    assign w_timeout = w_busy && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter idles at zero outside BUSY, so every BUSY entry starts fresh
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_to_cnt  <= (w_busy && !bus.bus_ack && !w_timeout) ? r_to_cnt + 1'b1 : '0;
            r_bus_err <= w_timeout && !bus.bus_ack;
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign bus.bus_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_discard   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= DATA_W'(ZERO_WORD);
            r_mem_rdata <= DATA_W'(ZERO_WORD);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= bus.mem_we;
                        r_bus_sel   <= bus.mem_sel;
                        r_bus_addr  <= bus.mem_addr;
                        r_bus_wdata <= bus.mem_wdata;
                        r_state     <= ST_MEM_BUSY;
                    end else if (bus.if_req && !bus.flush) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= SEL_WORD;
                        r_bus_addr  <= bus.if_addr;
                        r_bus_wdata <= '0;
                        r_discard   <= 1'b0;
                        r_state     <= ST_IF_BUSY;
                    end
                end
                ST_IF_BUSY: begin
                    if (bus.bus_ack || w_timeout) begin
                        r_bus_req <= 1'b0;
                        // A flushed fetch still finishes on the bus but its word is dropped
                        if (r_discard || bus.flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_if_rdata <= bus.bus_ack ? bus.bus_rdata : DATA_W'(ZERO_WORD);
                            r_state    <= ST_IF_DONE;
                        end
                    end else if (bus.flush) begin
                        r_discard <= 1'b1;
                    end
                end
                ST_MEM_BUSY: begin
                    if (bus.bus_ack || w_timeout) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we)
                            r_mem_rdata <= bus.bus_ack ? bus.bus_rdata : DATA_W'(ZERO_WORD);
                        r_state <= ST_MEM_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_idle    = (r_state == ST_IDLE);
    assign w_arb_mem = (w_idle && bus.mem_req) || (r_state == ST_MEM_BUSY);
    assign w_arb_if  = (w_idle && bus.if_req && !bus.mem_req)
                     || (r_state == ST_IF_BUSY)
                     || ((r_state == ST_MEM_BUSY) && bus.if_req);

    mem_bus_arbiter_stall_encoder u_stall_encoder (
        .arb_mem     (w_arb_mem),
        .stallreq_ex (bus.stallreq_ex),
        .stallreq_id (bus.stallreq_id),
        .arb_if      (w_arb_if),
        .stall       (w_stall)
    );

    assign bus.stall     = rst ? STALL_NONE : w_stall;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.mem_rdata = r_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter
// Vector table, directed corner sequences and randomized traffic for the arbiter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       mem_req;
        logic       if_req;
        logic       flush;
        logic       ex;
        logic       id;
        logic [5:0] stall;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        is_mem;
        logic        we;
        logic        discard;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.if_req      = 1'b0;
        bus_if.if_addr     = '0;
        bus_if.mem_req     = 1'b0;
        bus_if.mem_we      = 1'b0;
        bus_if.mem_sel     = '0;
        bus_if.mem_addr    = '0;
        bus_if.mem_wdata   = '0;
        bus_if.stallreq_id = 1'b0;
        bus_if.stallreq_ex = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.bus_rdata   = '0;
        bus_if.bus_ack     = 1'b0;
    endtask

    // Number of stalled stages, oldest-request-first, turned into a low-ones mask
    function automatic logic [5:0] stall_of(input logic arb_mem, input logic ex,
                                            input logic id, input logic arb_if);
        int n;
        n = arb_mem ? 5 : ex ? 4 : id ? 3 : arb_if ? 2 : 0;
        return 6'((1 << n) - 1);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        cur;
        logic        done_pend;
        logic [31:0] exp_if, exp_mem;
        int          busy_n;
        logic        idle, am, ai;

        //              mem  if   fl   ex   id   stall
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b001111};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000111};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011111};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        check("rst_bus_req",   32'(bus_if.bus_req),   32'h0);
        check("rst_bus_we",    32'(bus_if.bus_we),    32'h0);
        check("rst_bus_sel",   32'(bus_if.bus_sel),   32'h0);
        check("rst_bus_addr",  bus_if.bus_addr,       32'h0);
        check("rst_bus_wdata", bus_if.bus_wdata,      32'h0);
        check("rst_if_rdata",  bus_if.if_rdata,       32'h0);
        check("rst_mem_rdata", bus_if.mem_rdata,      32'h0);
        check("rst_stall",     32'(bus_if.stall),     32'h0);
        check("rst_bus_err",   32'(bus_if.bus_err),   32'h0);
        tick();

        // Each vector is applied in IDLE; reset before the edge keeps the FSM there
        for (int i = 0; i < 11; i++) begin
            bus_if.mem_req     = vecs[i].mem_req;
            bus_if.if_req      = vecs[i].if_req;
            bus_if.flush       = vecs[i].flush;
            bus_if.stallreq_ex = vecs[i].ex;
            bus_if.stallreq_id = vecs[i].id;
            #2;
            check($sformatf("vec%0d_stall", i), 32'(bus_if.stall), 32'(vecs[i].stall));
            check($sformatf("vec%0d_bus_req", i), 32'(bus_if.bus_req), 32'h0);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            idle_inputs();
        end

        // Reset while a store is in flight
        bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_sel = 4'b0011;
        bus_if.mem_addr = 32'h200; bus_if.mem_wdata = 32'h1234;
        tick();
        #2;
        check("rmid_busy_req", 32'(bus_if.bus_req), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #2;
        check("rmid_bus_req", 32'(bus_if.bus_req), 32'h0);
        check("rmid_stall",   32'(bus_if.stall),   32'h0);
        bus_if.if_req = 1'b1;
        #1;
        check("rmid_idle",    32'(bus_if.stall),   32'h03);
        bus_if.if_req = 1'b0;
        tick();

        // Lone fetch, ack in third BUSY cycle
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h40;
        #2;
        check("fetch_req_stall", 32'(bus_if.stall), 32'h03);
        tick();
        for (int k = 0; k < 3; k++) begin
            bus_if.bus_ack   = (k == 2);
            bus_if.bus_rdata = (k == 2) ? 32'h2401_0005 : 32'h0;
            #2;
            check($sformatf("fetch_busy%0d_stall", k), 32'(bus_if.stall), 32'h03);
            check($sformatf("fetch_busy%0d_req", k),   32'(bus_if.bus_req), 32'h1);
            check($sformatf("fetch_busy%0d_addr", k),  bus_if.bus_addr, 32'h40);
            check($sformatf("fetch_busy%0d_sel", k),   32'(bus_if.bus_sel), 32'hF);
            check($sformatf("fetch_busy%0d_we", k),    32'(bus_if.bus_we), 32'h0);
            tick();
        end
        bus_if.bus_ack = 1'b0;
        #2;
        check("fetch_done_rdata", bus_if.if_rdata, 32'h2401_0005);
        check("fetch_done_stall", 32'(bus_if.stall), 32'h0);
        check("fetch_done_req",   32'(bus_if.bus_req), 32'h0);
        bus_if.if_req = 1'b0;
        tick();

        // Simultaneous MEM load and IF fetch
        bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_sel = 4'hF;
        bus_if.mem_addr = 32'h100; bus_if.if_req = 1'b1; bus_if.if_addr = 32'h44;
        #2;
        check("both_req_stall", 32'(bus_if.stall), 32'h1F);
        tick();
        for (int k = 0; k < 2; k++) begin
            bus_if.bus_ack   = (k == 1);
            bus_if.bus_rdata = (k == 1) ? 32'hDEAD_BEEF : 32'h0;
            #2;
            check($sformatf("both_busy%0d_stall", k), 32'(bus_if.stall), 32'h1F);
            check($sformatf("both_busy%0d_addr", k),  bus_if.bus_addr, 32'h100);
            check($sformatf("both_busy%0d_we", k),    32'(bus_if.bus_we), 32'h0);
            tick();
        end
        bus_if.bus_ack = 1'b0;
        #2;
        check("both_mem_rdata", bus_if.mem_rdata, 32'hDEAD_BEEF);
        check("both_done_stall", 32'(bus_if.stall), 32'h0);
        bus_if.mem_req = 1'b0;
        tick();
        #2;
        check("both_if_idle_stall", 32'(bus_if.stall), 32'h03);
        tick();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
        #2;
        check("both_if_addr", bus_if.bus_addr, 32'h44);
        tick();
        bus_if.bus_ack = 1'b0;
        #2;
        check("both_if_rdata", bus_if.if_rdata, 32'hCAFE_F00D);
        bus_if.if_req = 1'b0;
        tick();

        // Store: bus fields held until ack, mem_rdata untouched
        bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_sel = 4'b0011;
        bus_if.mem_addr = 32'h200; bus_if.mem_wdata = 32'h1234;
        tick();
        bus_if.mem_sel = 4'hC; bus_if.mem_addr = 32'h999; bus_if.mem_wdata = 32'h5678;
        for (int k = 0; k < 3; k++) begin
            bus_if.bus_ack   = (k == 2);
            bus_if.bus_rdata = 32'h5555_5555;
            #2;
            check($sformatf("st%0d_req", k),   32'(bus_if.bus_req), 32'h1);
            check($sformatf("st%0d_we", k),    32'(bus_if.bus_we), 32'h1);
            check($sformatf("st%0d_sel", k),   32'(bus_if.bus_sel), 32'h3);
            check($sformatf("st%0d_addr", k),  bus_if.bus_addr, 32'h200);
            check($sformatf("st%0d_wdata", k), bus_if.bus_wdata, 32'h1234);
            tick();
        end
        bus_if.bus_ack = 1'b0;
        #2;
        check("st_mem_rdata", bus_if.mem_rdata, 32'hDEAD_BEEF);
        check("st_done_req",  32'(bus_if.bus_req), 32'h0);
        bus_if.mem_req = 1'b0;
        tick();

        // Flush during IF_BUSY: completion consumed, IF_DONE skipped
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h80;
        tick();
        bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
        tick();
        bus_if.bus_ack = 1'b0;
        #2;
        check("flush_if_rdata", bus_if.if_rdata, 32'hCAFE_F00D);
        check("flush_idle_stall", 32'(bus_if.stall), 32'h03);
        check("flush_bus_req", 32'(bus_if.bus_req), 32'h0);
        bus_if.if_req = 1'b0;
        tick();

`ifdef MEM_BUS_TIMEOUT_EN
        bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h300;
        tick();
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("to_busy%0d_req", k), 32'(bus_if.bus_req), 32'h1);
            check($sformatf("to_busy%0d_err", k), 32'(bus_if.bus_err), 32'h0);
            tick();
        end
        #2;
        check("to_err",       32'(bus_if.bus_err), 32'h1);
        check("to_req",       32'(bus_if.bus_req), 32'h0);
        check("to_mem_rdata", bus_if.mem_rdata, 32'h0);
        bus_if.mem_req = 1'b0;
        tick();
        #2;
        check("to_err_clear", 32'(bus_if.bus_err), 32'h0);
        tick();
`endif

        // Randomized traffic against a transaction-level model
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
        done_pend = 1'b0;
        exp_if = 32'h0;
        exp_mem = 32'h0;
        busy_n = 0;
        for (int c = 0; c < 3000; c++) begin
            bus_if.mem_req     = ($urandom_range(0, 3) == 0);
            bus_if.if_req      = ($urandom_range(0, 1) == 0);
            bus_if.mem_we      = ($urandom_range(0, 1) == 0);
            bus_if.mem_sel     = 4'($urandom);
            bus_if.mem_addr    = $urandom;
            bus_if.mem_wdata   = $urandom;
            bus_if.if_addr     = $urandom;
            bus_if.stallreq_ex = ($urandom_range(0, 7) == 0);
            bus_if.stallreq_id = ($urandom_range(0, 7) == 0);
            bus_if.flush       = ($urandom_range(0, 5) == 0);
            bus_if.bus_rdata   = $urandom;
            bus_if.bus_ack     = cur.valid ? ((busy_n == 3) || ($urandom_range(0, 2) == 0))
                                           : ($urandom_range(0, 7) == 0);

            idle = !cur.valid && !done_pend;
            am   = (idle && bus_if.mem_req) || (cur.valid && cur.is_mem);
            ai   = (idle && bus_if.if_req && !bus_if.mem_req) || (cur.valid && !cur.is_mem)
                 || (cur.valid && cur.is_mem && bus_if.if_req);
            #2;
            check("rnd_stall", 32'(bus_if.stall),
                  32'(stall_of(am, bus_if.stallreq_ex, bus_if.stallreq_id, ai)));
            check("rnd_bus_req", 32'(bus_if.bus_req), 32'(cur.valid));
            check("rnd_if_rdata", bus_if.if_rdata, exp_if);
            check("rnd_mem_rdata", bus_if.mem_rdata, exp_mem);
            check("rnd_bus_err", 32'(bus_if.bus_err), 32'h0);
            if (cur.valid) begin
                check("rnd_bus_addr", bus_if.bus_addr, cur.addr);
                check("rnd_bus_sel", 32'(bus_if.bus_sel), 32'(cur.sel));
                check("rnd_bus_we", 32'(bus_if.bus_we), 32'(cur.we));
                if (cur.we) check("rnd_bus_wdata", bus_if.bus_wdata, cur.wdata);
            end

            if (cur.valid) begin
                if (bus_if.bus_ack) begin
                    if (cur.is_mem) begin
                        if (!cur.we) exp_mem = bus_if.bus_rdata;
                        done_pend = 1'b1;
                    end else if (!(cur.discard || bus_if.flush)) begin
                        exp_if = bus_if.bus_rdata;
                        done_pend = 1'b1;
                    end
                    cur.valid = 1'b0;
                end else begin
                    if (!cur.is_mem && bus_if.flush) cur.discard = 1'b1;
                    busy_n++;
                end
            end else if (done_pend) begin
                done_pend = 1'b0;
            end else if (bus_if.mem_req) begin
                cur = '{1'b1, 1'b1, bus_if.mem_we, 1'b0, bus_if.mem_sel,
                        bus_if.mem_addr, bus_if.mem_wdata};
                busy_n = 0;
            end else if (bus_if.if_req && !bus_if.flush) begin
                cur = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, bus_if.if_addr, 32'h0};
                busy_n = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch stage (IF) and the MEM stage.
- Sequences each multi-cycle bus transaction and returns the read data to the requester.
- Generates the 6-bit pipeline stall vector that freezes the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits beside the pipeline control logic and merges the arbiter's own stall needs with the stall requests from ID (load-use) and EX (multi-cycle ops).

Parameters:
- ADDR_W, 32, width of bus and requester addresses.
- DATA_W, 32, width of the data bus.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF needs an instruction word.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, registered.
- mem_req  in  1  MEM stage load/store pending.
- mem_we  in  1  1 = store.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data, registered.
- stallreq_id  in  1  ID stall request.
- stallreq_ex  in  1  EX stall request.
- flush  in  1  exception/branch flush of younger stages.
- bus_req  out  1  bus cycle valid.
- bus_we  out  1  bus write enable.
- bus_sel  out  4  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data.
- bus_ack  in  1  one-cycle transfer-complete strobe.
- stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = stop.
- bus_err  out  1  timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset value of every output is 0: if_rdata, mem_rdata, all bus_* outputs, stall, bus_err. State returns to IDLE. Any in-flight transaction is abandoned; the bus slave must tolerate bus_req dropping.
- States are IDLE, IF_BUSY, MEM_BUSY, IF_DONE and MEM_DONE.
- IDLE:
  - mem_req has priority, because it is the older instruction. On mem_req, latch the request into the bus_* outputs and go to MEM_BUSY.
  - Otherwise, on if_req, latch the fetch (bus_we=0, bus_sel=4'hF) and go to IF_BUSY.
  - A request seen in IDLE drives bus_req high on the next cycle.
- IF_BUSY / MEM_BUSY:
  - bus_req and all bus_* outputs are held stable until bus_ack.
  - On bus_ack, capture bus_rdata into if_rdata or mem_rdata, drop bus_req, and go to the matching DONE state.
  - For stores, mem_rdata is left unchanged.
- IF_DONE / MEM_DONE: last exactly one cycle with no stall from the arbiter, so the pipeline consumes the result. Then go to IDLE.
- Minimum transaction: request sampled in cycle 0, bus_req in cycle 1, ack in cycle 1 at the earliest, DONE in cycle 2, IDLE in cycle 3.
- Arbiter stall requests (combinational from state and inputs):
  - arb_mem = mem_req in IDLE, or state is MEM_BUSY.
  - arb_if = (if_req in IDLE and not mem_req), or state is IF_BUSY, or (state is MEM_BUSY and if_req).
- Stall vector, highest priority first:
  - arb_mem -> 6'b011111.
  - stallreq_ex -> 6'b001111.
  - stallreq_id -> 6'b000111.
  - arb_if -> 6'b000011.
  - otherwise -> 0.
  - stall is registered-free combinational output.
- Flush:
  - During IF_BUSY, set a discard flag. The transaction still completes, but the state goes to IDLE (skipping IF_DONE) and if_rdata is not updated.
  - During MEM_BUSY, flush is ignored.
  - In IDLE, flush suppresses acceptance of if_req for that cycle.
- Simultaneous events:
  - mem_req and if_req in the same cycle: MEM wins; IF is served afterwards.
  - bus_ack outside a BUSY state is ignored.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- With the macro:
  - An 8-bit+ counter clears on entry to a BUSY state and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES: drop bus_req, pulse bus_err for 1 cycle, load rdata with 32'h0, and go to the DONE state.
- Without the macro: no counter; bus_err is constant 0; BUSY waits indefinitely for bus_ack.

Decomposition:
- Shared defines file: stall-vector patterns (STALL_MEM, STALL_EX, STALL_ID, STALL_IF, STALL_NONE), Stop/NoStop, state encodings, ZeroWord.
- One natural sub-module: stall_encoder, the combinational priority encoder from requests to the 6-bit stall vector.

Test Plan:
- Reset mid-MEM_BUSY (store in flight) -> next cycle bus_req=0, stall=0, state IDLE.
- Lone fetch: if_req=1, addr 0x00000040; bus_ack after 3 cycles with rdata 0x24010005 -> stall=6'b000011 until ack; if_rdata=0x24010005; stall=0 in IF_DONE.
- Simultaneous if_req and mem_req (load 0x100, ack returns 0xDEADBEEF) -> MEM served first with stall=6'b011111, mem_rdata=0xDEADBEEF; IF then served.
- Store (we=1, sel=4'b0011, wdata 0x1234) -> bus outputs match and are held stable until ack; mem_rdata unchanged.
- Flush during IF_BUSY -> ack consumed, if_rdata unchanged, IF_DONE skipped.
- MEM_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> bus_err pulses after 4 BUSY cycles, rdata=0, then IDLE.
